// File: rtl/mb16_pkg.sv
// mb16_pkg
// Shared definitions for the radix-8 Booth multiplier harness and its
// stream controller.
//   MB_WIDTH     : operand width
//   MB_LAT       : cycles from operand update to product on mul_p
//   MB_DEPTH     : result FIFO entries in the stream controller
//   mb_product_t : unsigned 2*MB_WIDTH product word
//   credit_op_e  : per-cycle action applied to the credit counter
package mb16_pkg;

    localparam int MB_WIDTH = 16;
    localparam int MB_LAT   = 3;
    localparam int MB_DEPTH = 8;

    typedef logic [2*MB_WIDTH-1:0] mb_product_t;

    // An issue and a pop in the same cycle cancel out, so the counter
    // only ever needs to hold, step up, or step down.
    typedef enum logic [1:0] {
        CR_HOLD = 2'd0,
        CR_INC  = 2'd1,
        CR_DEC  = 2'd2
    } credit_op_e;

endpackage

// File: rtl/mb16_res_fifo.sv
// mb16_res_fifo
// Synchronous result FIFO with registered storage and an asynchronous
// active-low reset on the pointers.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (clears pointers only)
//   push   : write din this edge
//   din    : write data
//   pop    : drop the head entry this edge (ignored when empty)
//   dout   : head entry, read straight from storage
//   full   : DEPTH entries held
//   empty  : no entries held
module mb16_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells a wrapped (full) pointer pair apart from
    // an equal (empty) one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop on an empty FIFO is dropped, so a simultaneous push into an
    // empty FIFO is simply stored. A push into a full FIFO only lands when
    // the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage is not reset; only entries between the pointers are ever read
    // as valid data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rptr[AW-1:0]];

endmodule

// File: rtl/mb16_stream_ctrl.sv
// mb16_stream_ctrl
// Operand-issue and result-collection controller for the registered
// radix-8 Booth multiplier harness. Operand pairs are taken on a
// valid/ready stream, driven to the harness, tracked through its fixed
// latency and returned in order on a valid/ready result stream. A credit
// counter covering in-flight and queued products keeps issue from ever
// overrunning the result FIFO.
// Ports:
//   CLK       : clock, rising edge
//   RST       : asynchronous active-low reset
//   in_valid  : operand pair present
//   in_ready  : controller can accept a pair this cycle
//   in_x/in_y : multiplicand / multiplier
//   mul_x/y   : registered operands to the harness
//   mul_p     : product from the harness
//   out_valid : result available
//   out_ready : consumer takes the head result
//   out_p     : head result
//   busy      : products in flight or queued
module mb16_stream_ctrl
    import mb16_pkg::*;
#(
    parameter int WIDTH = MB_WIDTH,
    parameter int LAT   = MB_LAT,
    parameter int DEPTH = MB_DEPTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    logic [LAT-1:0] vpipe;
    logic [CW-1:0]  credits_used;
    credit_op_e     credit_op;
    logic           issue;
    logic           capture;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;

    // in_ready looks only at the registered credit count, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (credits_used < CREDIT_MAX);
    assign issue     = in_valid && in_ready;
    assign capture   = vpipe[LAT-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (credits_used != '0);

    // Operands only move on an issue edge so idle cycles leave the
    // multiplier inputs quiet.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mul_x <= '0;
            mul_y <= '0;
        end else if (issue) begin
            mul_x <= in_x;
            mul_y <= in_y;
        end
    end

    // One bit per harness stage; the top bit marks the edge where mul_p
    // carries a product worth keeping. Clearing it on reset is what makes
    // stale harness outputs harmless, since the harness itself is not reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vpipe <= '0;
        end else begin
            vpipe <= (vpipe << 1) | LAT'(issue);
        end
    end

    // A capture just moves a credit from in-flight to queued, so only issue
    // and pop affect the total.
    always_comb begin
        credit_op = CR_HOLD;
        if (issue && !pop) begin
            credit_op = CR_INC;
        end else if (pop && !issue) begin
            credit_op = CR_DEC;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            credits_used <= '0;
        end else begin
            case (credit_op)
                CR_INC:  credits_used <= credits_used + 1'b1;
                CR_DEC:  credits_used <= credits_used - 1'b1;
                default: credits_used <= credits_used;
            endcase
        end
    end

    mb16_res_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (capture),
        .din   (mul_p),
        .pop   (pop),
        .dout  (out_p),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The credit scheme guarantees a captured product always has a slot.
    assert property (@(posedge CLK) disable iff (!RST)
                     capture |-> (!fifo_full || pop));

    assert property (@(posedge CLK) disable iff (!RST)
                     credits_used <= CREDIT_MAX);

endmodule

// File: doc/mb16_stream_ctrl.md
# mb16_stream_ctrl

Operand-issue and result-collection controller for the registered 16-bit radix-8 Booth multiplier harness. It accepts operand pairs on a valid/ready stream and drives them onto the harness operand inputs. It tracks each product through the harness's fixed pipeline latency and returns products in order on a valid/ready result stream. Credit-based issue ensures products are never lost when the result consumer stalls.

## Interface

- WIDTH, 16: operand width; product width is 2*WIDTH.
- LAT, 3: cycles from the issue edge (mul_x/mul_y update) until mul_p holds that pair's product.
- DEPTH, 8: result FIFO entries, power of two, ≥ LAT+2.

- CLK in 1: single clock, rising edge.
- RST in 1: asynchronous, active-low reset.
- in_valid in 1: operand pair present.
- in_ready out 1: controller can issue this cycle.
- in_x in WIDTH: multiplicand.
- in_y in WIDTH: multiplier.
- mul_x out WIDTH: to harness mx, registered.
- mul_y out WIDTH: to harness my, registered.
- mul_p in 2*WIDTH: from harness product output.
- out_valid out 1: result FIFO non-empty.
- out_ready in 1: consumer accepts head.
- out_p out 2*WIDTH: FIFO head product.
- busy out 1: in-flight count or FIFO occupancy nonzero.

## Operation

- **Issue.** When in_valid && in_ready is true at an edge, mul_x/mul_y load in_x/in_y and a 1 enters bit 0 of the LAT-deep valid shift register. Otherwise mul_x/mul_y hold their value and a 0 enters the shift register.
- **Capture.** When the shift register output is 1, mul_p is pushed into the FIFO on that edge.
- **Credit.** credits_used = inflight + occupancy, registered, range 0..DEPTH.
  - in_ready = (credits_used < DEPTH). It is combinational from registers only, with no path from out_ready or in_valid.
  - credits_used increments on issue and decrements on pop. Simultaneous issue and pop leaves it unchanged. A capture moves a credit from in-flight to FIFO and leaves the total unchanged.
- **Output.** out_valid = FIFO non-empty. out_p = head entry, driven from storage with no mul_p bypass. A pop occurs on out_valid && out_ready.
- **Order.** Products return strictly in issue order. Products are unsigned 2*WIDTH values passed through unmodified; the controller does no arithmetic on them.
- **FIFO boundaries.**
  - A push to a full FIFO is impossible by construction. Assertion: push implies not full, or pop in the same cycle.
  - A pop from an empty FIFO is ignored.
  - Simultaneous push and pop on an empty FIFO: the push is stored and out_valid rises next cycle.
  - Read and write pointers wrap at DEPTH; the extra MSB distinguishes full from empty.

## Timing

- Reset (RST=0, asynchronous):
  - mul_x = 0, mul_y = 0.
  - Valid shift register = 0, FIFO pointers = 0, credits_used = 0.
  - out_valid = 0, busy = 0.
  - in_ready = 1 from the first cycle after release.
- Issue at edge t means the product is captured at edge t+LAT and out_valid is high after edge t+LAT. End-to-end latency, in_valid accept to out_valid, is LAT+1 cycles.
- Throughput is one pair per cycle with out_ready held high, provided DEPTH ≥ LAT+2.
- With out_ready low, exactly DEPTH pairs are accepted, then in_ready = 0 until a pop. in_ready returns 1 one cycle after the pop edge.
- Reset mid-operation: in-flight and queued products are discarded. The harness registers are not reset, so stale mul_p values arriving after reset are ignored because the valid pipe is cleared.
- mul_x/mul_y change only on issue edges, so idle cycles cause no toggling on the multiplier inputs.

## Structure

- Shared package mb16_pkg holds MB_WIDTH (16), MB_LAT (3), and the product type of 2*MB_WIDTH bits. The harness and this controller both use it.
- One sub-module, mb16_res_fifo: synchronous FIFO parameterized by width and depth, with push/pop/full/empty, async active-low reset, and registered-storage read.
- The valid shift register, credit counter and operand registers live in the top level.

## Test plan

- **Reset values.** Hold RST=0 with random inputs, then release → mul_x = mul_y = 0, out_valid = 0, busy = 0, in_ready = 1.
- **Single product.** Issue in_x=0x1234, in_y=0x0056 with out_ready=1 → out_valid for exactly one cycle, 4 cycles after acceptance, out_p = 0x00061D78. busy then returns to 0.
- **Streaming.** Issue 64 back-to-back random pairs with out_ready=1 → in_ready never drops, results arrive in order at 1/cycle and match a reference model.
- **Backpressure.** Hold out_ready=0 and offer 12 pairs → exactly 8 are accepted, then in_ready=0. Raise out_ready → 8 ordered results, and in_ready re-asserts one cycle after the first pop.
- **Boundary operands.** Issue 0xFFFF×0xFFFF, 0×0xFFFF and 0x8000×0x0002 → out_p = 0xFFFE0001, 0x00000000 and 0x00010000.
- **Mid-stream reset.** Issue 5 pairs, assert RST at cycle 2 for one cycle, release, then issue 0x0003×0x0005 → only one result appears, out_p = 0x0000000F, with no stale outputs.
